// File: rtl/cdc_bus_arb_pkg.sv
// Shared types and constants for the CDC bus arbiter.
package cdc_bus_arb_pkg;

  typedef enum logic [0:0] {
    StIdle = 1'b0,
    StGap  = 1'b1
  } arb_state_e;

  localparam logic [7:0] DefaultGap = 8'd8;

  // Population count of up to 16 simultaneous drop events.
  function automatic logic [4:0] count_ones(input logic [15:0] vec);
    logic [4:0] n;
    n = '0;
    for (int i = 0; i < 16; i++) begin
      n = n + {4'b0000, vec[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/cdc_arb_rr.sv
// Round-robin pick: first pending requester after last_grant, wrapping around.
module cdc_arb_rr #(
  parameter int pNUM_REQ  = 4,
  parameter int pID_WIDTH = 2
) (
  input  logic [pNUM_REQ-1:0]  pending,
  input  logic [pID_WIDTH-1:0] last_grant,
  output logic [pNUM_REQ-1:0]  grant,
  output logic                 valid
);

  logic found;

  // Two passes with constant indices: upper part above last_grant, then the wrap.
  always_comb begin
    grant = '0;
    found = 1'b0;
    for (int i = 0; i < pNUM_REQ; i++) begin
      if (!found && pending[i] && (i > int'(last_grant))) begin
        grant[i] = 1'b1;
        found    = 1'b1;
      end
    end
    for (int i = 0; i < pNUM_REQ; i++) begin
      if (!found && pending[i] && (i <= int'(last_grant))) begin
        grant[i] = 1'b1;
        found    = 1'b1;
      end
    end
  end

  assign valid = |pending;

endmodule

// File: rtl/cdc_bus_arb.sv
// Arbitrates one-shot requests onto a shared CDC pulse bus with a programmable gap.
// Optional drop counter enabled by defining CDC_ARB_DROP_COUNT_EN.
module cdc_bus_arb
  import cdc_bus_arb_pkg::*;
#(
  parameter int pNUM_REQ    = 4,
  parameter int pDATA_WIDTH = 8,
  parameter int pID_WIDTH   = 2
) (
  input  logic                            clk,
  input  logic                            reset_i,
  input  logic                            clear_error,
  input  logic [7:0]                      gap_cycles,
  input  logic [pNUM_REQ-1:0]             req_pulse,
  input  logic [pNUM_REQ*pDATA_WIDTH-1:0] req_data,
  output logic [pNUM_REQ-1:0]             req_pending,
  output logic [pNUM_REQ-1:0]             req_drop,
  output logic                            xfer_pulse,
  output logic [pID_WIDTH+pDATA_WIDTH-1:0] xfer_data,
  input  logic                            xfer_overflow,
  output logic                            arb_error,
  output logic [7:0]                      drop_count
);

  arb_state_e                        state_q, state_d;
  logic [7:0]                        gap_cnt_q, gap_cnt_d;
  logic [pID_WIDTH-1:0]              last_q, last_d;
  logic [pNUM_REQ-1:0]               pending_q, pending_d;
  logic [pDATA_WIDTH-1:0]            slot_q [pNUM_REQ];
  logic [pDATA_WIDTH-1:0]            slot_d [pNUM_REQ];
  logic [pNUM_REQ-1:0]               drop_q, drop_d;
  logic                              err_q, err_d;
  logic                              xfer_pulse_q, xfer_pulse_d;
  logic [pID_WIDTH+pDATA_WIDTH-1:0]  xfer_data_q, xfer_data_d;

  logic [pNUM_REQ-1:0]    grant_oh;
  logic                   rr_valid;
  logic                   do_grant;
  logic [pID_WIDTH-1:0]   grant_id;
  logic [pDATA_WIDTH-1:0] grant_payload;
  logic [pNUM_REQ-1:0]    drop_ev;

  cdc_arb_rr #(
    .pNUM_REQ  (pNUM_REQ),
    .pID_WIDTH (pID_WIDTH)
  ) u_rr (
    .pending    (pending_q),
    .last_grant (last_q),
    .grant      (grant_oh),
    .valid      (rr_valid)
  );

  assign do_grant = (state_q == StIdle) && rr_valid;

  always_comb begin
    grant_id      = '0;
    grant_payload = '0;
    for (int i = 0; i < pNUM_REQ; i++) begin
      if (grant_oh[i]) begin
        grant_id      = pID_WIDTH'(i);
        grant_payload = slot_q[i];
      end
    end
  end

  // A strobe into the slot being granted refills it instead of counting as a drop.
  always_comb begin
    pending_d = pending_q;
    slot_d    = slot_q;
    drop_ev   = '0;
    for (int i = 0; i < pNUM_REQ; i++) begin
      if (do_grant && grant_oh[i]) begin
        pending_d[i] = 1'b0;
      end
      if (req_pulse[i]) begin
        if (!pending_q[i] || (do_grant && grant_oh[i])) begin
          pending_d[i] = 1'b1;
          slot_d[i]    = req_data[i*pDATA_WIDTH +: pDATA_WIDTH];
        end else begin
          drop_ev[i] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    drop_d = drop_ev | (drop_q & ~{pNUM_REQ{clear_error}});
    err_d  = (|drop_ev) | xfer_overflow | (err_q & ~clear_error);
  end

  always_comb begin
    state_d      = state_q;
    gap_cnt_d    = gap_cnt_q;
    last_d       = last_q;
    xfer_pulse_d = 1'b0;
    xfer_data_d  = '0;
    unique case (state_q)
      StIdle: begin
        if (rr_valid) begin
          state_d      = StGap;
          gap_cnt_d    = (gap_cycles == 8'd0) ? 8'd1 : gap_cycles;
          last_d       = grant_id;
          xfer_pulse_d = 1'b1;
          xfer_data_d  = {grant_id, grant_payload};
        end
      end
      StGap: begin
        if (gap_cnt_q <= 8'd1) begin
          state_d = StIdle;
        end else begin
          gap_cnt_d = gap_cnt_q - 8'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      state_q      <= StIdle;
      gap_cnt_q    <= '0;
      last_q       <= pID_WIDTH'(pNUM_REQ - 1);
      pending_q    <= '0;
      drop_q       <= '0;
      err_q        <= 1'b0;
      xfer_pulse_q <= 1'b0;
      xfer_data_q  <= '0;
      for (int i = 0; i < pNUM_REQ; i++) begin
        slot_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      gap_cnt_q    <= gap_cnt_d;
      last_q       <= last_d;
      pending_q    <= pending_d;
      drop_q       <= drop_d;
      err_q        <= err_d;
      xfer_pulse_q <= xfer_pulse_d;
      xfer_data_q  <= xfer_data_d;
      for (int i = 0; i < pNUM_REQ; i++) begin
        slot_q[i] <= slot_d[i];
      end
    end
  end

`ifdef CDC_ARB_DROP_COUNT_EN
  logic [7:0] drop_cnt_q, drop_cnt_d;
  logic [8:0] drop_sum;

  // Clear and new drops in one cycle: the new drops survive.
  always_comb begin
    drop_sum   = {1'b0, (clear_error ? 8'd0 : drop_cnt_q)} + 9'(count_ones(16'(drop_ev)));
    drop_cnt_d = drop_sum[8] ? 8'hFF : drop_sum[7:0];
  end

  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      drop_cnt_q <= '0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign drop_count = drop_cnt_q;
`else
  assign drop_count = '0;
`endif

  assign req_pending = pending_q;
  assign req_drop    = drop_q;
  assign arb_error   = err_q;
  assign xfer_pulse  = xfer_pulse_q;
  assign xfer_data   = xfer_data_q;

endmodule

// File: tb/tb_cdc_bus_arb.sv
// Bench for cdc_bus_arb: vector table, directed corner sequences, random vs. reference model.
module tb_cdc_bus_arb;
  import cdc_bus_arb_pkg::*;

  localparam int NR = 4;
  localparam int DW = 8;
  localparam int IW = 2;

  logic                clk = 1'b0;
  logic                reset_i;
  logic                clear_error;
  logic [7:0]          gap_cycles;
  logic [NR-1:0]       req_pulse;
  logic [NR*DW-1:0]    req_data;
  logic                xfer_overflow;
  logic [NR-1:0]       req_pending;
  logic [NR-1:0]       req_drop;
  logic                xfer_pulse;
  logic [IW+DW-1:0]    xfer_data;
  logic                arb_error;
  logic [7:0]          drop_count;

  always #5 clk = ~clk;

  cdc_bus_arb #(
    .pNUM_REQ    (NR),
    .pDATA_WIDTH (DW),
    .pID_WIDTH   (IW)
  ) dut (
    .clk           (clk),
    .reset_i       (reset_i),
    .clear_error   (clear_error),
    .gap_cycles    (gap_cycles),
    .req_pulse     (req_pulse),
    .req_data      (req_data),
    .req_pending   (req_pending),
    .req_drop      (req_drop),
    .xfer_pulse    (xfer_pulse),
    .xfer_data     (xfer_data),
    .xfer_overflow (xfer_overflow),
    .arb_error     (arb_error),
    .drop_count    (drop_count)
  );

  int n_vec = 0;
  int n_bad = 0;

  // Reference model: slots, last winner, and the cycle at which a new grant may happen.
  bit            m_pend [NR];
  logic [DW-1:0] m_data [NR];
  int            m_last, m_free_at, cyc, m_cnt;
  logic          m_pulse;
  logic [IW+DW-1:0] m_xdata;
  logic [NR-1:0] m_drop;
  logic          m_err;

  function automatic void model_reset();
    for (int i = 0; i < NR; i++) begin
      m_pend[i] = 1'b0;
      m_data[i] = '0;
    end
    m_last = NR - 1; m_free_at = 0; cyc = 0; m_cnt = 0;
    m_pulse = 1'b0; m_xdata = '0; m_drop = '0; m_err = 1'b0;
  endfunction

  function automatic logic [7:0] exp_count();
`ifdef CDC_ARB_DROP_COUNT_EN
    return 8'(m_cnt);
`else
    return 8'd0;
`endif
  endfunction

  task automatic predict();
    int w, g, nd;
    logic [NR-1:0] ev;
    w = -1; ev = '0; nd = 0;
    if (cyc >= m_free_at) begin
      for (int k = 1; k <= NR; k++) begin
        int idx;
        idx = (m_last + k) % NR;
        if (w < 0 && m_pend[idx]) w = idx;
      end
    end
    m_pulse = (w >= 0);
    m_xdata = '0;
    if (w >= 0) begin
      m_xdata   = {IW'(w), m_data[w]};
      m_last    = w;
      g         = (gap_cycles == 8'd0) ? 1 : int'(gap_cycles);
      m_free_at = cyc + 1 + g;
      m_pend[w] = 1'b0;
    end
    for (int i = 0; i < NR; i++) begin
      if (req_pulse[i]) begin
        if (!m_pend[i]) begin
          m_pend[i] = 1'b1;
          m_data[i] = req_data[i*DW +: DW];
        end else begin
          ev[i] = 1'b1;
          nd++;
        end
      end
    end
    m_err  = ((ev != '0) || xfer_overflow) ? 1'b1 : (clear_error ? 1'b0 : m_err);
    m_drop = clear_error ? ev : (m_drop | ev);
    m_cnt  = (clear_error ? 0 : m_cnt) + nd;
    if (m_cnt > 255) m_cnt = 255;
    cyc++;
  endtask

  task automatic compare();
    logic [NR-1:0] ep;
    for (int i = 0; i < NR; i++) ep[i] = m_pend[i];
    n_vec++;
    if (req_pending !== ep || xfer_pulse !== m_pulse || xfer_data !== m_xdata ||
        req_drop !== m_drop || arb_error !== m_err || drop_count !== exp_count()) begin
      n_bad++;
      $display("FAIL model cyc=%0d got pend=%b pulse=%b data=%h drop=%b err=%b cnt=%0d", cyc,
               req_pending, xfer_pulse, xfer_data, req_drop, arb_error, drop_count,
               " want pend=%b pulse=%b data=%h drop=%b err=%b cnt=%0d", ep, m_pulse, m_xdata,
               m_drop, m_err, exp_count());
    end
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  task automatic step();
    predict();
    @(posedge clk);
    #1;
    compare();
  endtask

  task automatic idle_inputs();
    req_pulse = '0; req_data = '0; clear_error = 1'b0; xfer_overflow = 1'b0;
  endtask

  // Reset asserted mid-cycle: outputs must drop immediately, before any clock edge.
  task automatic do_reset();
    reset_i = 1'b1;
    #1;
    model_reset();
    compare();
    @(posedge clk);
    #1;
    reset_i = 1'b0;
    compare();
  endtask

  typedef struct packed {
    logic [NR-1:0]    pulse;
    logic [NR*DW-1:0] data;
    logic [7:0]       gap;
    logic             clr;
    logic             ovf;
    logic             e_pulse;
    logic [IW+DW-1:0] e_xdata;
    logic [NR-1:0]    e_pend;
    logic             e_err;
  } vec_t;

  vec_t tbl [24];
  int   pc_cyc [$];
  logic [IW+DW-1:0] pc_dat [$];

  initial begin
    reset_i = 1'b1; gap_cycles = 8'd4;
    idle_inputs();
    model_reset();

    // Row r is applied in cycle r after reset; expectations are for cycle r+1.
    for (int r = 0; r < 24; r++) begin
      tbl[r] = '{pulse: '0, data: '0, gap: 8'd4, clr: 1'b0, ovf: 1'b0,
                 e_pulse: 1'b0, e_xdata: '0, e_pend: '0, e_err: 1'b0};
    end
    tbl[10].pulse = 4'b0100; tbl[10].data = 32'h005A_0000; tbl[10].e_pend = 4'b0100;
    tbl[11].e_pulse = 1'b1;  tbl[11].e_xdata = 10'h25A;
    tbl[12].ovf = 1'b1;      tbl[12].clr = 1'b1;           tbl[12].e_err = 1'b1;
    tbl[13].clr = 1'b1;
    tbl[15].pulse = 4'b1000; tbl[15].data = 32'h7700_0000; tbl[15].e_pend = 4'b1000;
    tbl[16].pulse = 4'b1000; tbl[16].data = 32'h1100_0000; tbl[16].e_pend = 4'b1000;
    tbl[16].e_pulse = 1'b1;  tbl[16].e_xdata = 10'h377;
    for (int r = 17; r <= 20; r++) tbl[r].e_pend = 4'b1000;
    tbl[21].e_pulse = 1'b1;  tbl[21].e_xdata = 10'h311;

    @(posedge clk);
    #1;
    reset_i = 1'b0;
    chk("reset_pending", 32'(req_pending), 32'd0);
    chk("reset_pulse", 32'(xfer_pulse), 32'd0);
    chk("reset_err", 32'(arb_error), 32'd0);

    for (int r = 0; r < 24; r++) begin
      req_pulse = tbl[r].pulse; req_data = tbl[r].data; gap_cycles = tbl[r].gap;
      clear_error = tbl[r].clr; xfer_overflow = tbl[r].ovf;
      step();
      n_vec++;
      if (xfer_pulse !== tbl[r].e_pulse || xfer_data !== tbl[r].e_xdata ||
          req_pending !== tbl[r].e_pend || arb_error !== tbl[r].e_err ||
          req_drop !== '0) begin
        n_bad++;
        $display("FAIL vec[%0d] got pulse=%b data=%h pend=%b err=%b drop=%b want %b %h %b %b 0",
                 r, xfer_pulse, xfer_data, req_pending, arb_error, req_drop, tbl[r].e_pulse,
                 tbl[r].e_xdata, tbl[r].e_pend, tbl[r].e_err);
      end
    end
    idle_inputs();

    // All four strobed together, gap 3: grants 0,1,2,3 four cycles apart.
    do_reset();
    gap_cycles = 8'd3; req_pulse = 4'b1111; req_data = 32'hA3A2_A1A0;
    step();
    idle_inputs();
    for (int k = 1; k <= 16; k++) begin
      step();
      if (xfer_pulse) begin
        pc_cyc.push_back(k + 1);
        pc_dat.push_back(xfer_data);
      end
    end
    chk("rr_pulse_count", 32'(pc_cyc.size()), 32'd4);
    for (int j = 0; j < pc_cyc.size() && j < 4; j++) begin
      chk("rr_pulse_cycle", 32'(pc_cyc[j]), 32'(2 + 4 * j));
      chk("rr_pulse_data", 32'(pc_dat[j]), 32'({2'(j), 8'(8'hA0 + j)}));
    end

    // Second strobe to an occupied slot during the gap is dropped; first payload survives.
    do_reset();
    gap_cycles = DefaultGap; req_pulse = 4'b0001; req_data = 32'h0000_0033;
    step();
    idle_inputs();
    step();
    chk("drop_first_pulse", 32'(xfer_pulse), 32'd1);
    step();
    req_pulse = 4'b0010; req_data = 32'h0000_4400;
    step();
    idle_inputs();
    step();
    req_pulse = 4'b0010; req_data = 32'h0000_5500;
    step();
    idle_inputs();
    chk("drop_flag", 32'(req_drop), 32'b0010);
    chk("drop_err", 32'(arb_error), 32'd1);
    chk("drop_pending", 32'(req_pending), 32'b0010);
`ifdef CDC_ARB_DROP_COUNT_EN
    chk("drop_count", 32'(drop_count), 32'd1);
`else
    chk("drop_count", 32'(drop_count), 32'd0);
`endif
    begin
      int hit;
      hit = -1;
      for (int k = 1; k <= 20 && hit < 0; k++) begin
        step();
        if (xfer_pulse) begin
          hit = 6 + k;
          chk("drop_kept_data", 32'(xfer_data), 32'h144);
        end
      end
      chk("drop_issue_cycle", 32'(hit), 32'd11);
    end

    // Reset in the middle of a gap with two slots pending.
    do_reset();
    gap_cycles = 8'd6; req_pulse = 4'b0001; req_data = 32'h0000_0010;
    step();
    idle_inputs();
    step();
    step();
    req_pulse = 4'b1100; req_data = 32'hDD_CC_0000;
    step();
    idle_inputs();
    chk("rst_pre_pending", 32'(req_pending), 32'b1100);
    step();
    do_reset();
    chk("rst_pending", 32'(req_pending), 32'd0);
    begin
      int pulses;
      pulses = 0;
      for (int k = 0; k < 10; k++) begin
        step();
        if (xfer_pulse) pulses++;
      end
      chk("rst_no_pulse", 32'(pulses), 32'd0);
    end
    req_pulse = 4'b1001; req_data = 32'h4400_0033;
    step();
    idle_inputs();
    step();
    chk("rst_prio_pulse", 32'(xfer_pulse), 32'd1);
    chk("rst_prio_data", 32'(xfer_data), 32'h033);

    // Continuous strobing drives the drop counter into saturation.
    gap_cycles = 8'd8;
    for (int k = 0; k < 120; k++) begin
      req_pulse = 4'b1111; req_data = $urandom;
      step();
    end
    idle_inputs();

    // Random traffic against the model.
    for (int k = 0; k < 3000; k++) begin
      req_pulse     = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'd0;
      req_data      = $urandom;
      clear_error   = ($urandom_range(0, 15) == 0);
      xfer_overflow = ($urandom_range(0, 31) == 0);
      if (k % 50 == 0) gap_cycles = 8'($urandom_range(0, 5));
      if ($urandom_range(0, 499) == 0) do_reset();
      else step();
    end
    idle_inputs();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
